// File: rtl/tracker_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tracker_fsm
// Description : Line-tracking decision FSM feeding the motor stage; filters
//               the IR sensors and sequences count, follow, junction, recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module tracker_fsm #(
    parameter int unsigned FILTER_LEN      = 4,
    parameter int unsigned COUNT_CYCLES    = 300_000_000,
    parameter int unsigned CHOOSE_CYCLES   = 20_000_000,
    parameter int unsigned TURN_MIN_CYCLES = 30_000_000,
    parameter int unsigned LOST_CYCLES     = 10_000_000,
    parameter int unsigned BACK_CYCLES     = 100_000_000,
    parameter logic [15:0] DIR_SEQ         = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sensor,
    output logic [4:0] mode,
    output logic [4:0] last_mode
);

    typedef enum logic [4:0] {
        ST_IDLE         = 5'd0,
        ST_START        = 5'd1,
        ST_COUNT        = 5'd2,
        ST_STRAIGHT     = 5'd3,
        ST_CHOOSE       = 5'd4,
        ST_LEFT         = 5'd5,
        ST_RIGHT        = 5'd6,
        ST_BACK         = 5'd7,
        ST_LITTLE_LEFT  = 5'd8,
        ST_LITTLE_RIGHT = 5'd9,
        ST_FINISH       = 5'd29,
        ST_STOP         = 5'd30,
        ST_ERROR        = 5'd31
    } state_t;

    localparam int unsigned      c_run_w       = $clog2(FILTER_LEN + 1);
    localparam logic [c_run_w-1:0] c_run_full  = c_run_w'(FILTER_LEN);
    localparam logic [31:0]      c_count_last  = 32'(COUNT_CYCLES - 1);
    localparam logic [31:0]      c_choose_last = 32'(CHOOSE_CYCLES - 1);
    localparam logic [31:0]      c_turn_min    = 32'(TURN_MIN_CYCLES);
    localparam logic [31:0]      c_lost_last   = 32'(LOST_CYCLES - 1);
    localparam logic [31:0]      c_back_last   = 32'(BACK_CYCLES - 1);

    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_cand;
    logic [2:0]         r_sf;
    logic [c_run_w-1:0] r_run;
    logic [c_run_w-1:0] w_run;

    state_t      r_state;
    state_t      r_last;
    state_t      w_next;
    logic        w_reenter;
    logic        w_change;
    logic        w_follow;
    logic [31:0] r_tmr;
    logic [31:0] r_lost;
    logic [2:0]  r_jidx;
    logic [2:0]  w_jidx;
    logic [1:0]  w_dir;

    // Run length of the synchronized value, saturating at FILTER_LEN.
    always_comb begin
        w_run = c_run_w'(1);
        if (r_sync2 == r_cand) begin
            w_run = (r_run == c_run_full) ? r_run : r_run + c_run_w'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_cand  <= 3'b000;
            r_run   <= '0;
            r_sf    <= 3'b000;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_run   <= w_run;
            // 101 is physically impossible on a single line, so keep the last pattern.
            if (w_run == c_run_full && r_sync2 != 3'b101) begin
                r_sf <= r_sync2;
            end
        end
    end

    assign w_follow = (r_state == ST_STRAIGHT) || (r_state == ST_LITTLE_LEFT) ||
                      (r_state == ST_LITTLE_RIGHT);
    assign w_dir    = DIR_SEQ[{r_jidx, 1'b0} +: 2];

    always_comb begin
        w_next    = r_state;
        w_reenter = 1'b0;
        w_jidx    = r_jidx;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_START;
            end
            ST_START: begin
                w_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (r_tmr == c_count_last) w_next = ST_STRAIGHT;
            end
            ST_STRAIGHT, ST_LITTLE_LEFT, ST_LITTLE_RIGHT: begin
                if (r_sf == 3'b111) begin
                    w_next = ST_CHOOSE;
                end else if (r_lost == c_lost_last) begin
                    w_next = ST_BACK;
                end else if (r_sf == 3'b010) begin
                    w_next    = ST_STRAIGHT;
                    w_reenter = (r_state == ST_STRAIGHT);
                end else if (r_sf == 3'b100 || r_sf == 3'b110) begin
                    w_next = ST_LITTLE_LEFT;
                end else if (r_sf == 3'b001 || r_sf == 3'b011) begin
                    w_next = ST_LITTLE_RIGHT;
                end
            end
            ST_CHOOSE: begin
                if (r_tmr == c_choose_last) begin
                    if (r_jidx == 3'd7) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_jidx = r_jidx + 3'd1;
                        case (w_dir)
                            2'b00:   w_next = ST_STRAIGHT;
                            2'b01:   w_next = ST_LEFT;
                            2'b10:   w_next = ST_RIGHT;
                            default: w_next = ST_FINISH;
                        endcase
                    end
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (r_tmr >= c_turn_min && r_sf == 3'b010) w_next = ST_STRAIGHT;
            end
            ST_BACK: begin
                if (r_sf != 3'b000) begin
                    w_next = ST_STRAIGHT;
                end else if (r_tmr == c_back_last) begin
                    w_next = ST_ERROR;
                end
            end
            ST_FINISH: begin
                w_next = ST_STOP;
            end
            ST_STOP, ST_ERROR: begin
                if (start) begin
                    w_next = ST_IDLE;
                    w_jidx = 3'd0;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_change = (w_next != r_state) || w_reenter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ST_IDLE;
            r_tmr  <= '0;
            r_lost <= '0;
            r_jidx <= 3'd0;
        end else begin
            r_jidx <= w_jidx;
            if (w_change) begin
                r_last <= r_state;
                r_tmr  <= '0;
            end else if (r_tmr != '1) begin
                r_tmr <= r_tmr + 32'd1;
            end
            if (w_follow && r_sf == 3'b000 && !w_change) begin
                r_lost <= r_lost + 32'd1;
            end else begin
                r_lost <= '0;
            end
        end
    end

    assign mode      = r_state;
    assign last_mode = r_last;

endmodule
`default_nettype wire

// File: tb/tb_tracker_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tracker_fsm
// Description : Directed self-checking bench for tracker_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tracker_fsm;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] sensor;
    logic [4:0] mode;
    logic [4:0] last_mode;

    int n_tests;
    int n_fail;

    tracker_fsm #(
        .FILTER_LEN      (2),
        .COUNT_CYCLES    (10),
        .CHOOSE_CYCLES   (4),
        .TURN_MIN_CYCLES (6),
        .LOST_CYCLES     (5),
        .BACK_CYCLES     (8),
        .DIR_SEQ         (16'h00E1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sensor    (sensor),
        .mode      (mode),
        .last_mode (last_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation point: 1 ns after each rising edge; inputs change here too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse from IDLE and run through COUNT into STRAIGHT (12 cycles).
    task automatic go_straight(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL %s_enter mode=%0d expected=3", tag, mode);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sensor = 3'b010;
        tick(); tick();
        n_tests++;
        if (mode !== 5'd0 || last_mode !== 5'd0) begin
            n_fail++;
            $display("FAIL reset mode=%0d last=%0d expected=0/0", mode, last_mode);
        end
        rst = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (mode !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_hold mode=%0d expected=0", mode);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (mode !== 5'd1) begin
            n_fail++;
            $display("FAIL start_state mode=%0d expected=1", mode);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd2) begin
                n_fail++;
                $display("FAIL count_cycle%0d mode=%0d expected=2", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd3 || last_mode !== 5'd2) begin
            n_fail++;
            $display("FAIL count_exit mode=%0d last=%0d expected=3/2", mode, last_mode);
        end
    endtask

    task automatic test_line_follow();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL start_ignored mode=%0d expected=3", mode);
        end
        // sensor change reaches sf after 4 edges, mode after 5
        sensor = 3'b110;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd3) begin
                n_fail++;
                $display("FAIL ll_latency%0d mode=%0d expected=3", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd8 || last_mode !== 5'd3) begin
            n_fail++;
            $display("FAIL ll_enter mode=%0d last=%0d expected=8/3", mode, last_mode);
        end
        tick();
        sensor = 3'b010;
        for (int i = 7; i <= 10; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd8) begin
                n_fail++;
                $display("FAIL ll_hold%0d mode=%0d expected=8", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd3 || last_mode !== 5'd8) begin
            n_fail++;
            $display("FAIL ll_return mode=%0d last=%0d expected=3/8", mode, last_mode);
        end
        // Staying on the line re-enters STRAIGHT, which refreshes last_mode.
        tick();
        n_tests++;
        if (mode !== 5'd3 || last_mode !== 5'd3) begin
            n_fail++;
            $display("FAIL reentry mode=%0d last=%0d expected=3/3", mode, last_mode);
        end
    endtask

    // Route 0x00E1 decodes to junctions: left, straight, right, finish.
    task automatic test_junction_left();
        sensor = 3'b111;
        repeat (4) tick();
        for (int i = 5; i <= 8; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd4) begin
                n_fail++;
                $display("FAIL jl_choose%0d mode=%0d expected=4", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd5 || last_mode !== 5'd4) begin
            n_fail++;
            $display("FAIL jl_left mode=%0d last=%0d expected=5/4", mode, last_mode);
        end
        tick(); tick();
        sensor = 3'b010;
        for (int i = 12; i <= 15; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd5) begin
                n_fail++;
                $display("FAIL jl_turn%0d mode=%0d expected=5", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL jl_exit mode=%0d expected=3", mode);
        end
    endtask

    task automatic test_junction_straight();
        sensor = 3'b111;
        repeat (5) tick();
        sensor = 3'b010;
        n_tests++;
        if (mode !== 5'd4) begin
            n_fail++;
            $display("FAIL js_choose mode=%0d expected=4", mode);
        end
        repeat (4) tick();
        n_tests++;
        if (mode !== 5'd3 || last_mode !== 5'd4) begin
            n_fail++;
            $display("FAIL js_exit mode=%0d last=%0d expected=3/4", mode, last_mode);
        end
        tick();
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL js_hold mode=%0d expected=3", mode);
        end
    endtask

    // Line is already back before the turn begins: exit must wait for the minimum.
    task automatic test_junction_right();
        sensor = 3'b111;
        repeat (5) tick();
        sensor = 3'b010;
        repeat (4) tick();
        n_tests++;
        if (mode !== 5'd6) begin
            n_fail++;
            $display("FAIL jr_right mode=%0d expected=6", mode);
        end
        for (int i = 10; i <= 15; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd6) begin
                n_fail++;
                $display("FAIL jr_min%0d mode=%0d expected=6", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL jr_exit mode=%0d expected=3", mode);
        end
    endtask

    task automatic test_junction_finish();
        sensor = 3'b111;
        repeat (5) tick();
        sensor = 3'b010;
        n_tests++;
        if (mode !== 5'd4) begin
            n_fail++;
            $display("FAIL jf_choose mode=%0d expected=4", mode);
        end
        repeat (4) tick();
        n_tests++;
        if (mode !== 5'd29) begin
            n_fail++;
            $display("FAIL jf_finish mode=%0d expected=29", mode);
        end
        tick();
        n_tests++;
        if (mode !== 5'd30 || last_mode !== 5'd29) begin
            n_fail++;
            $display("FAIL jf_stop mode=%0d last=%0d expected=30/29", mode, last_mode);
        end
        tick(); tick();
        n_tests++;
        if (mode !== 5'd30) begin
            n_fail++;
            $display("FAIL jf_stop_hold mode=%0d expected=30", mode);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (mode !== 5'd0 || last_mode !== 5'd30) begin
            n_fail++;
            $display("FAIL stop_to_idle mode=%0d last=%0d expected=0/30", mode, last_mode);
        end
    endtask

    task automatic test_lost_recovery();
        go_straight("lost");
        sensor = 3'b000;
        repeat (8) tick();
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL lost_early mode=%0d expected=3", mode);
        end
        tick();
        n_tests++;
        if (mode !== 5'd7 || last_mode !== 5'd3) begin
            n_fail++;
            $display("FAIL lost_back mode=%0d last=%0d expected=7/3", mode, last_mode);
        end
        sensor = 3'b001;
        repeat (4) tick();
        n_tests++;
        if (mode !== 5'd7) begin
            n_fail++;
            $display("FAIL back_hold mode=%0d expected=7", mode);
        end
        tick();
        n_tests++;
        if (mode !== 5'd3) begin
            n_fail++;
            $display("FAIL back_recover mode=%0d expected=3", mode);
        end
        tick();
        n_tests++;
        if (mode !== 5'd9) begin
            n_fail++;
            $display("FAIL little_right mode=%0d expected=9", mode);
        end
        // Second loss starts from LITTLE_RIGHT and is never recovered.
        sensor = 3'b000;
        repeat (9) tick();
        n_tests++;
        if (mode !== 5'd7) begin
            n_fail++;
            $display("FAIL lost2_back mode=%0d expected=7", mode);
        end
        for (int i = 10; i <= 16; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd7) begin
                n_fail++;
                $display("FAIL back_wait%0d mode=%0d expected=7", i, mode);
            end
        end
        tick();
        n_tests++;
        if (mode !== 5'd31 || last_mode !== 5'd7) begin
            n_fail++;
            $display("FAIL error mode=%0d last=%0d expected=31/7", mode, last_mode);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (mode !== 5'd0) begin
            n_fail++;
            $display("FAIL error_to_idle mode=%0d expected=0", mode);
        end
    endtask

    task automatic test_glitch();
        sensor = 3'b010;
        go_straight("glitch");
        sensor = 3'b100;
        tick();
        sensor = 3'b010;
        for (int i = 1; i <= 10; i++) begin
            n_tests++;
            if (mode !== 5'd3) begin
                n_fail++;
                $display("FAIL glitch%0d mode=%0d expected=3", i, mode);
            end
            tick();
        end
        sensor = 3'b101;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (mode !== 5'd3) begin
                n_fail++;
                $display("FAIL invalid101_%0d mode=%0d expected=3", i, mode);
            end
        end
        sensor = 3'b010;
        repeat (6) tick();
    endtask

    task automatic test_reset_in_left();
        sensor = 3'b111;
        repeat (9) tick();
        n_tests++;
        if (mode !== 5'd5) begin
            n_fail++;
            $display("FAIL jidx_cleared mode=%0d expected=5", mode);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (mode !== 5'd0 || last_mode !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset mode=%0d last=%0d expected=0/0", mode, last_mode);
        end
        tick();
        rst = 1'b0;
        sensor = 3'b010;
        repeat (3) tick();
        n_tests++;
        if (mode !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle mode=%0d expected=0", mode);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_start();
        test_line_follow();
        test_junction_left();
        test_junction_straight();
        test_junction_right();
        test_junction_finish();
        test_lost_recovery();
        test_glitch();
        test_reset_in_left();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
